mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port synchronous memory between two requesters: the CPU
// (c_*) and the debug/loader port (d_*). Grants are combinational in the
// cycle a request is seen in IDLE. A tie goes round-robin using a one-bit
// pointer that records the last winner. Writes finish in their grant cycle.
// Reads take one extra cycle (RD_WAIT), in which the memory's registered
// read data is sent back to the requester that issued the read.
//
// Parameters
//   AW        memory address width
//   DW        memory data width
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high reset
//   c_req      CPU request, held until c_gnt
//   c_we       CPU write (1) / read (0)
//   c_addr     CPU address
//   c_wdata    CPU write data
//   c_gnt      CPU access accepted this cycle
//   c_rvalid   CPU read data valid (single-cycle pulse)
//   c_rdata    CPU read data, zero unless c_rvalid
//   c_stall    CPU hold: request pending but not granted
//   d_*        same meanings for the debug/loader requester (no stall)
//   mem_en     memory access strobe
//   mem_we     memory write enable
//   mem_addr   memory address
//   mem_wdata  memory write data
//   mem_rdata  memory read data, valid the cycle after a read strobe
// ---------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,

  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  output logic          c_stall,

  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [DW-1:0] d_rdata,

  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic STATE_IDLE    = 1'b0;
  localparam logic STATE_RD_WAIT = 1'b1;

  // state_q     : arbiter FSM state
  // lastDbg_q   : 1 when the debug port won the most recent grant
  // ownerDbg_q  : 1 when the read in flight belongs to the debug port
  logic state_q, state_d;
  logic lastDbg_q, lastDbg_d;
  logic ownerDbg_q, ownerDbg_d;

  logic          grantOpen;
  logic          cWins;
  logic          dWins;
  logic          anyGnt;
  logic          winWe;
  logic [AW-1:0] winAddr;
  logic [DW-1:0] winWdata;
  logic          rdReturn;

  // Grant decision. Grants are only possible in IDLE and never while reset
  // is asserted. On a tie the requester that did not win last time takes
  // this one; a lone requester always wins.
  always_comb begin
    grantOpen = (state_q == STATE_IDLE) && !reset;
    cWins     = grantOpen && c_req && (!d_req || lastDbg_q);
    dWins     = grantOpen && d_req && !cWins;
    anyGnt    = cWins || dWins;
  end

  // Select the winner's access signals for the memory port.
  always_comb begin
    if (dWins) begin
      winWe    = d_we;
      winAddr  = d_addr;
      winWdata = d_wdata;
    end else begin
      winWe    = c_we;
      winAddr  = c_addr;
      winWdata = c_wdata;
    end
  end

  // The memory port is only driven in grant cycles; at all other times it
  // is held at zero so the memory sees a clean, quiet bus.
  always_comb begin
    mem_en    = anyGnt;
    mem_we    = anyGnt ? winWe : 1'b0;
    mem_addr  = anyGnt ? winAddr : '0;
    mem_wdata = anyGnt ? winWdata : '0;
  end

  // Read return. RD_WAIT lasts exactly one cycle, so rvalid is a single
  // pulse that goes only to the owner. rdata is forced to zero whenever its
  // rvalid is low. Reset suppresses the pulse, which aborts a read that
  // reset interrupts.
  always_comb begin
    rdReturn = (state_q == STATE_RD_WAIT) && !reset;
    c_rvalid = rdReturn && !ownerDbg_q;
    d_rvalid = rdReturn && ownerDbg_q;
    c_rdata  = c_rvalid ? mem_rdata : '0;
    d_rdata  = d_rvalid ? mem_rdata : '0;
  end

  // Grants and the CPU stall. The stall stays purely combinational, so it
  // also covers requests held off during RD_WAIT. It is forced low during
  // reset.
  always_comb begin
    c_gnt   = cWins;
    d_gnt   = dWins;
    c_stall = !reset && c_req && !cWins;
  end

  // Next-state logic. Every grant moves the pointer to the winner. A granted
  // read parks the FSM in RD_WAIT for one cycle and records its owner. A
  // granted write leaves the FSM in IDLE, so writes can run back to back.
  always_comb begin
    state_d    = state_q;
    lastDbg_d  = lastDbg_q;
    ownerDbg_d = ownerDbg_q;
    case (state_q)
      STATE_IDLE: begin
        if (anyGnt) begin
          lastDbg_d = dWins;
          if (!winWe) begin
            state_d    = STATE_RD_WAIT;
            ownerDbg_d = dWins;
          end
        end
      end
      STATE_RD_WAIT: begin
        state_d = STATE_IDLE;
      end
      default: begin
        state_d = STATE_IDLE;
      end
    endcase
  end

  // State registers. Reset makes the debug port look like the last winner,
  // so the CPU wins the first tie after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= STATE_IDLE;
      lastDbg_q  <= 1'b1;
      ownerDbg_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      lastDbg_q  <= lastDbg_d;
      ownerDbg_q <= ownerDbg_d;
    end
  end

endmodule
